intmatmul_seq_engine: RTL
=========================

Name: intmatmul_seq_engine

Overview:
Parametrised, time-multiplexed successor to the scan-loaded integer matrix-vector multiplier. It holds an NxN matrix and an N-vector of unsigned words, loaded by scan writes on the global bus. On command it computes all N dot products on pLanes shared MAC lanes under an FSM. Results, overflow flag and status are read back over the same bus. It sits directly on the global RD/WR/Addr/Data bus as a self-contained benchmark core.

Parameters:
pVectorSize, 16, N: matrix dimension and vector length; must be a multiple of pLanes
pWordSize, 8, element width in bits; must be 16 or less
pLanes, 4, number of parallel MAC lanes (rows computed concurrently)
pAccWidth, 20, accumulator and result width; must be 32 or less and at least 2*pWordSize

Ports:
Clk  in  1  single clock; all state is updated on the rising edge
Reset  in  1  asynchronous, active-low reset
RD  in  1  bus read strobe
WR  in  1  bus write strobe
Addr  in  15  bus address; Addr[2:0] selects the register, Addr[14:3] is the result index
DataIn  in  32  bus write data
DataOut  out  32  bus read data, combinational; 0 when RD=0
Busy  out  1  high while the FSM is in COMPUTE
Done  out  1  high from completion until the next start or clear

Behaviour:
- Reset (Reset=0, asynchronous):
  - FSM goes to IDLE; Busy=0, Done=0, overflow=0, saturate mode=0.
  - All counters, accumulators and result words are cleared to 0.
  - Matrix and vector storage are cleared to 0.
- Address map (Addr[2:0]):
  - 0 W: matrix scan. Shift the matrix down one word; DataIn[pWordSize-1:0] enters the top slot. After N*N writes, the k-th word written is element (k/N, k%N).
  - 1 W: vector scan. Same shifting scheme over N words.
  - 2 W: control. bit0 start, bit1 clear, bit2 saturate mode (latched on every control write).
  - 3 R: status. {29'b0, overflow, Done, Busy}.
  - 4 R: result[Addr[14:3]], zero-extended to 32 bits. An index of N or more reads 0.
  - Other offsets: writes are ignored, reads return 0.
- RD and WR in the same cycle: both take effect. The read returns the pre-edge value.
- While Busy=1, scan writes and start are ignored. Reads remain valid; results that are mid-computation may show the previous value.
- Clear takes priority over start in the same write:
  - FSM goes to IDLE; Done=0, overflow=0.
  - The result array is zeroed.
  - Matrix and vector are kept.
  - Clear aborts a computation in progress.
- FSM states IDLE, COMPUTE, DONE:
  - IDLE or DONE -> COMPUTE on an accepted start. Done=0, group g=0, column c=0, accumulators=0; overflow is kept (sticky until clear).
  - COMPUTE, every cycle: lane l computes acc[l] += M[g*pLanes+l][c] * V[c]. The product is 2*pWordSize bits, zero-extended.
  - At c=N-1: write result[g*pLanes+l] = final acc[l] for each lane, zero the accumulators, set c=0, g=g+1.
  - COMPUTE -> DONE when c=N-1 and g=N/pLanes-1.
- Latency: start accepted at edge t gives Busy=1 for exactly N*N/pLanes cycles. Done=1 at edge t+N*N/pLanes.
- Arithmetic: the accumulate sum is computed one bit wider than pAccWidth, and its carry bit detects overflow.
  - Wrap mode: keep the low pAccWidth bits.
  - Saturate mode: clamp to 2^pAccWidth-1.
  - Either mode: overflow is set on any lane carry.

Decomposition:
- intmatmul_pkg holds:
  - register offset constants (MAT=0, VEC=1, CTRL=2, STAT=3, RES=4);
  - control and status bit positions;
  - the FSM state enum {IDLE, COMPUTE, DONE}.
- One sub-module, intmatmul_mac_lane: a single multiply-accumulate lane with clear, enable, saturate input and overflow output. It is instantiated pLanes times.
- The top level keeps the FSM, scan storage, operand muxing, result array and bus decode.

Test Plan:
- Identity matrix, vector 1..16, start -> Busy for 64 cycles; then result[k]=k+1 for k=0..15, status=0x2.
- Matrix (r,c)=r+c, vector all 2, N=16 -> result[r]=32r+240, e.g. result[0]=240, result[15]=720.
- pAccWidth=16, all elements 255, wrap mode -> every result=57360, overflow=1. Same with saturate mode -> every result=65535, overflow=1.
- Scan write and second start issued mid-COMPUTE -> ignored; results equal the pre-write operand product; Done exactly 64 cycles after the first start.
- Clear at cycle 30 of COMPUTE -> Busy=0 next cycle, every result reads 0. A following start without reloading produces the correct results from the retained matrix and vector.
- Reset asserted mid-COMPUTE -> Busy and Done drop immediately without a clock edge; status=0, result[3]=0; read with Addr index 20 -> 0.

Source files
------------

// File: rtl/intmatmul_pkg.sv
// Shared definitions for the sequential integer matrix-vector engine:
// register offsets, control/status bit positions and the FSM state type.
package intmatmul_pkg;

    // Register offsets decoded from Addr[2:0]
    localparam logic [2:0] REG_MAT  = 3'd0;
    localparam logic [2:0] REG_VEC  = 3'd1;
    localparam logic [2:0] REG_CTRL = 3'd2;
    localparam logic [2:0] REG_STAT = 3'd3;
    localparam logic [2:0] REG_RES  = 3'd4;

    // Control register bit positions (write)
    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    localparam int CTRL_SAT   = 2;

    // Status register bit positions (read)
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVF  = 2;

    // Engine FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } engState_t;

endpackage

// File: rtl/intmatmul_mac_lane.sv
// One multiply-accumulate lane. The sum is formed one bit wider than the
// accumulator so the carry exposes overflow; in saturate mode a carry clamps
// the accumulator to all ones. accNext is the value the accumulator takes on
// the next enabled edge, so the top level can capture a row's final sum in
// the same cycle the lane is cleared for the next row.
module intmatmul_mac_lane #(
    parameter int pWordSize = 8,
    parameter int pAccWidth = 20
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 sat,
    input  logic [pWordSize-1:0] opA,
    input  logic [pWordSize-1:0] opB,
    output logic [pAccWidth-1:0] accNext,
    output logic                 carry
);

    localparam int SW = pAccWidth + 1;

    logic [pAccWidth-1:0]   acc;
    logic [2*pWordSize-1:0] prod;
    logic [SW-1:0]          sum;

    // Product, widened sum, carry and wrap/saturate selection
    always_comb begin
        prod  = {{pWordSize{1'b0}}, opA} * {{pWordSize{1'b0}}, opB};
        sum   = {1'b0, acc} + SW'(prod);
        carry = sum[pAccWidth];
        if (carry && sat) begin
            accNext = '1;
        end else begin
            accNext = sum[pAccWidth-1:0];
        end
    end

    // Accumulator register; clear wins over accumulate
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= accNext;
        end
    end

endmodule

// File: rtl/intmatmul_seq_engine.sv
// Time-multiplexed integer matrix-vector multiplier on the global bus.
// Matrix and vector are scan-loaded, then pLanes MAC lanes sweep the rows
// group by group, one column per cycle, writing each row's dot product into
// the result array when the last column is reached.
//
// Bus semantics: a write takes effect on the rising edge where WR=1; a read
// is purely combinational while RD=1 and returns the pre-edge state, so RD
// and WR in the same cycle both act. There is no ready/stall: every access
// completes in one cycle. Scan writes and start are dropped while Busy=1.
module intmatmul_seq_engine
    import intmatmul_pkg::*;
#(
    parameter int pVectorSize = 16,
    parameter int pWordSize   = 8,
    parameter int pLanes      = 4,
    parameter int pAccWidth   = 20
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RD,
    input  logic        WR,
    input  logic [14:0] Addr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Busy,
    output logic        Done
);

    localparam int N  = pVectorSize;
    localparam int NN = N * N;
    localparam int NG = N / pLanes;
    localparam int CW = (N  > 1) ? $clog2(N)  : 1;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    localparam int MW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [11:0] N_IDX = 12'(pVectorSize);

    engState_t state, stateNext;

    logic [CW-1:0]        col;
    logic [GW-1:0]        grp;
    logic [pWordSize-1:0] mat [NN];
    logic [pWordSize-1:0] vec [N];
    logic [pAccWidth-1:0] res [N];
    logic                 satMode;
    logic                 overflow;

    logic wrMat, wrVec, wrCtrl, clearCmd, startCmd;
    logic busy, lastCol, lastGrp, laneClr;

    logic [pWordSize-1:0] opA [pLanes];
    logic [pWordSize-1:0] opB;
    logic [pAccWidth-1:0] accNext [pLanes];
    logic [pLanes-1:0]    laneCarry;

    // Upper data bits are never consumed by any register
    logic unusedData;
    assign unusedData = ^DataIn[31:pWordSize];

    // Bus write decode and command qualification
    always_comb begin
        busy     = (state == COMPUTE);
        lastCol  = (col == CW'(N - 1));
        lastGrp  = (grp == GW'(NG - 1));
        wrMat    = WR && (Addr[2:0] == REG_MAT) && !busy;
        wrVec    = WR && (Addr[2:0] == REG_VEC) && !busy;
        wrCtrl   = WR && (Addr[2:0] == REG_CTRL);
        clearCmd = wrCtrl && DataIn[CTRL_CLEAR];
        startCmd = wrCtrl && DataIn[CTRL_START] && !DataIn[CTRL_CLEAR] && !busy;
        laneClr  = clearCmd || startCmd || (busy && lastCol);
    end

    // FSM state register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next-state logic; clear overrides everything
    always_comb begin
        stateNext = state;
        if (clearCmd) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (startCmd) stateNext = COMPUTE;
                COMPUTE:    if (lastCol && lastGrp) stateNext = DONE;
                default:    stateNext = IDLE;
            endcase
        end
    end

    // Column and row-group sweep counters
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            col <= '0;
            grp <= '0;
        end else if (clearCmd || startCmd) begin
            col <= '0;
            grp <= '0;
        end else if (busy) begin
            if (lastCol) begin
                col <= '0;
                grp <= lastGrp ? '0 : grp + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Scan storage: new words enter the top slot, older ones shift down
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NN; i++) mat[i] <= '0;
            for (int i = 0; i < N; i++)  vec[i] <= '0;
        end else begin
            if (wrMat) begin
                for (int i = 0; i < NN - 1; i++) mat[i] <= mat[i+1];
                mat[NN-1] <= DataIn[pWordSize-1:0];
            end
            if (wrVec) begin
                for (int i = 0; i < N - 1; i++) vec[i] <= vec[i+1];
                vec[N-1] <= DataIn[pWordSize-1:0];
            end
        end
    end

    // Saturate mode follows every control write; overflow is sticky until clear
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            satMode  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wrCtrl) satMode <= DataIn[CTRL_SAT];
            if (clearCmd) begin
                overflow <= 1'b0;
            end else if (busy && (|laneCarry)) begin
                overflow <= 1'b1;
            end
        end
    end

    // Operand fetch: lane l works on row grp*pLanes+l, all lanes share V[col]
    always_comb begin
        opB = vec[col];
        for (int l = 0; l < pLanes; l++) begin
            opA[l] = mat[MW'((int'(grp) * pLanes + l) * N + int'(col))];
        end
    end

    // MAC lanes
    for (genvar l = 0; l < pLanes; l++) begin : gLane
        intmatmul_mac_lane #(
            .pWordSize (pWordSize),
            .pAccWidth (pAccWidth)
        ) uLane (
            .Clk     (Clk),
            .Reset   (Reset),
            .clr     (laneClr),
            .en      (busy),
            .sat     (satMode),
            .opA     (opA[l]),
            .opB     (opB),
            .accNext (accNext[l]),
            .carry   (laneCarry[l])
        );
    end

    // Result array: capture final sums at the last column, zero on clear
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < N; i++) res[i] <= '0;
        end else if (clearCmd) begin
            for (int i = 0; i < N; i++) res[i] <= '0;
        end else if (busy && lastCol) begin
            for (int l = 0; l < pLanes; l++) begin
                res[CW'(int'(grp) * pLanes + l)] <= accNext[l];
            end
        end
    end

    assign Busy = busy;
    assign Done = (state == DONE);

    // Combinational read mux; idle bus reads 0
    always_comb begin
        DataOut = '0;
        if (RD) begin
            case (Addr[2:0])
                REG_STAT: begin
                    DataOut[STAT_BUSY] = busy;
                    DataOut[STAT_DONE] = (state == DONE);
                    DataOut[STAT_OVF]  = overflow;
                end
                REG_RES: begin
                    if (Addr[14:3] < N_IDX) DataOut = 32'(res[Addr[CW+2:3]]);
                end
                default: DataOut = '0;
            endcase
        end
    end

endmodule
